// File: rtl/gat_bram_load_ctrl.sv
// Host-to-BRAM load controller for the GAT core: converts host byte-addressed writes to
// word-addressed BRAM writes, tracks per-channel load progress and sequences core start/finish.
module gat_bram_load_ctrl #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 24,
    parameter int DEPTH_W = 19
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm,
    input  logic                         abort,
    input  logic                         layer_in,
    input  logic [NUM_CH*DEPTH_W-1:0]    ch_depth,
    input  logic [NUM_CH-1:0]            host_ena,
    input  logic [NUM_CH-1:0]            host_wea,
    input  logic [NUM_CH*(ADDR_W+2)-1:0] host_addr,
    input  logic [NUM_CH*32-1:0]         host_din,
    input  logic                         core_ready,
    output logic [NUM_CH-1:0]            bram_we,
    output logic [NUM_CH*ADDR_W-1:0]     bram_addr,
    output logic [NUM_CH*DATA_W-1:0]     bram_din,
    output logic [NUM_CH-1:0]            ch_done,
    output logic                         core_start,
    output logic                         core_layer,
    output logic                         layer_done,
    output logic [1:0]                   err_flags,
    output logic [31:0]                  status
);

    localparam int CNT_W = $clog2(NUM_CH + 1);
    localparam int CMP_W = (ADDR_W > DEPTH_W) ? ADDR_W : DEPTH_W;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, START = 2'd2, RUN = 2'd3} state_t;

    state_t              state, state_nxt;
    logic                run_armed;
    logic [DEPTH_W-1:0]  depth [NUM_CH];
    logic [DEPTH_W-1:0]  count [NUM_CH];
    logic [ADDR_W-1:0]   word_addr [NUM_CH];
    logic [23:0]         dropped;
    logic [24:0]         drop_sum;
    logic [CNT_W-1:0]    drop_inc;
    logic [NUM_CH-1:0]   accept, reject, unaligned, out_of_range;
    logic [1:0]          err_set;
    logic [3:0]          done4;
    logic                in_load, arm_take, finish;
    logic                unused_din_hi;

    assign in_load  = (state == LOAD) && !abort;
    assign arm_take = arm && (state == IDLE) && !abort;
    assign finish   = (state == RUN) && run_armed && core_ready && !abort;
    assign drop_sum = {1'b0, dropped} + 25'(drop_inc);

    always_comb begin
        accept        = '0;
        reject        = '0;
        unaligned     = '0;
        out_of_range  = '0;
        err_set       = '0;
        drop_inc      = '0;
        unused_din_hi = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            word_addr[i]    = host_addr[i*(ADDR_W+2)+2 +: ADDR_W];
            unaligned[i]    = host_addr[i*(ADDR_W+2) +: 2] != 2'b00;
            out_of_range[i] = CMP_W'(word_addr[i]) >= CMP_W'(depth[i]);
            accept[i]       = host_ena[i] && host_wea[i] && in_load && !unaligned[i]
                              && !out_of_range[i] && !ch_done[i];
            reject[i]       = host_ena[i] && host_wea[i] && !accept[i];
            // Error bits only flag bad writes the load phase would otherwise have taken.
            if (host_ena[i] && host_wea[i] && in_load && !ch_done[i]) begin
                err_set[0] = err_set[0] | unaligned[i];
                err_set[1] = err_set[1] | out_of_range[i];
            end
            drop_inc      = drop_inc + CNT_W'(reject[i]);
            unused_din_hi = unused_din_hi ^ (^host_din[i*32+DATA_W +: 32-DATA_W]);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm) state_nxt = LOAD;
            LOAD:    if (&ch_done) state_nxt = START;
            START:   state_nxt = RUN;
            RUN:     if (run_armed && core_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            run_armed  <= 1'b0;
            layer_done <= 1'b0;
            core_layer <= 1'b0;
            err_flags  <= '0;
            dropped    <= '0;
            bram_we    <= '0;
            bram_addr  <= '0;
            bram_din   <= '0;
            ch_done    <= '0;
            // NOTE: depth/count arrays are a handful of flops, not RAM, so they take the async reset.
            for (int i = 0; i < NUM_CH; i++) begin
                depth[i] <= '0;
                count[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            run_armed  <= (state == RUN);
            layer_done <= finish;
            bram_we    <= accept;
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept[i]) begin
                    bram_addr[i*ADDR_W +: ADDR_W] <= word_addr[i];
                    bram_din[i*DATA_W +: DATA_W]  <= host_din[i*32 +: DATA_W];
                end
            end
            if (arm_take) begin
                core_layer <= layer_in;
                err_flags  <= '0;
                dropped    <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    depth[i]   <= ch_depth[i*DEPTH_W +: DEPTH_W];
                    count[i]   <= '0;
                    ch_done[i] <= ch_depth[i*DEPTH_W +: DEPTH_W] == '0;
                end
            end else begin
                err_flags <= err_flags | err_set;
                dropped   <= drop_sum[24] ? 24'hFF_FFFF : drop_sum[23:0];
                for (int i = 0; i < NUM_CH; i++) begin
                    if (abort) begin
                        count[i]   <= '0;
                        ch_done[i] <= 1'b0;
                    end else if (accept[i]) begin
                        count[i] <= count[i] + DEPTH_W'(1);
                        if (count[i] + DEPTH_W'(1) == depth[i]) ch_done[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        done4              = '0;
        done4[NUM_CH-1:0]  = ch_done;
    end

    assign core_start = (state == START);
    assign status     = {state, 2'b00, done4, dropped};

endmodule

// File: tb/tb_gat_bram_load_ctrl.sv
// Directed self-checking bench for gat_bram_load_ctrl: load sequencing, error/drop
// accounting, abort/re-arm, zero-depth start and asynchronous reset.
module tb_gat_bram_load_ctrl;

    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 24;
    localparam int DEPTH_W = 19;

    logic                         clk = 1'b0;
    logic                         rst, arm, abort, layer_in, core_ready;
    logic [NUM_CH*DEPTH_W-1:0]    ch_depth;
    logic [NUM_CH-1:0]            host_ena, host_wea;
    logic [NUM_CH*(ADDR_W+2)-1:0] host_addr;
    logic [NUM_CH*32-1:0]         host_din;
    logic [NUM_CH-1:0]            bram_we, ch_done;
    logic [NUM_CH*ADDR_W-1:0]     bram_addr;
    logic [NUM_CH*DATA_W-1:0]     bram_din;
    logic                         core_start, core_layer, layer_done;
    logic [1:0]                   err_flags;
    logic [31:0]                  status;

    logic [ADDR_W+1:0]  a [NUM_CH];
    logic [31:0]        d [NUM_CH];
    logic [DEPTH_W-1:0] dep [NUM_CH];
    int tests = 0;
    int fails = 0;

    assign host_addr = {a[3], a[2], a[1], a[0]};
    assign host_din  = {d[3], d[2], d[1], d[0]};
    assign ch_depth  = {dep[3], dep[2], dep[1], dep[0]};

    always #5 clk = ~clk;

    gat_bram_load_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .layer_in(layer_in),
        .ch_depth(ch_depth), .host_ena(host_ena), .host_wea(host_wea),
        .host_addr(host_addr), .host_din(host_din), .core_ready(core_ready),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .ch_done(ch_done), .core_start(core_start), .core_layer(core_layer),
        .layer_done(layer_done), .err_flags(err_flags), .status(status)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_depth(input int d0, input int d1, input int d2, input int d3);
        dep[0] = DEPTH_W'(d0); dep[1] = DEPTH_W'(d1);
        dep[2] = DEPTH_W'(d2); dep[3] = DEPTH_W'(d3);
    endtask

    task automatic do_arm(input logic layer);
        layer_in = layer; arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic idle_wr();
        host_ena = '0; host_wea = '0;
    endtask

    localparam logic [3:0] WE_EXP   [4] = '{4'hF, 4'h7, 4'h5, 4'h1};
    localparam logic [3:0] DONE_EXP [4] = '{4'h8, 4'hA, 4'hE, 4'hF};

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; layer_in = 1'b0; core_ready = 1'b0;
        host_ena = '0; host_wea = '0;
        for (int i = 0; i < NUM_CH; i++) begin a[i] = '0; d[i] = '0; dep[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        check("reset_status", status, 32'h0);
        check("reset_outs", {28'h0, bram_we}, 32'h0);
        check("reset_start", {31'h0, core_start}, 32'h0);
        rst = 1'b0;
        step();

        // Sequential load, depths {4,2,3,1}
        set_depth(4, 2, 3, 1);
        do_arm(1'b1);
        check("arm_state_load", status, 32'h4000_0000);
        check("core_layer", {31'h0, core_layer}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                host_ena[i] = (k < int'(dep[i]));
                host_wea[i] = 1'b1;
                a[i] = 20'(4 * k);
                d[i] = 32'hA512_3456 + 32'(k);
            end
            step();
            check($sformatf("load_we_k%0d", k), {28'h0, bram_we}, {28'h0, WE_EXP[k]});
            check($sformatf("load_done_k%0d", k), {28'h0, ch_done}, {28'h0, DONE_EXP[k]});
            check($sformatf("load_addr0_k%0d", k), {14'h0, bram_addr[0 +: ADDR_W]}, 32'(k));
            check($sformatf("load_din0_k%0d", k), {8'h0, bram_din[0 +: DATA_W]}, 32'h0012_3456 + 32'(k));
        end
        check("ch2_last_addr", {14'h0, bram_addr[2*ADDR_W +: ADDR_W]}, 32'd2);
        check("no_start_yet", {31'h0, core_start}, 32'h0);
        idle_wr();
        step();
        check("start_pulse", {31'h0, core_start}, 32'h1);
        core_ready = 1'b1;
        step();
        check("run_first_start", {31'h0, core_start}, 32'h0);
        check("run_first_state", {30'h0, status[31:30]}, 32'd3);
        check("run_first_ld", {31'h0, layer_done}, 32'h0);
        step();
        check("run_second_ld", {31'h0, layer_done}, 32'h0);
        step();
        check("layer_done", {31'h0, layer_done}, 32'h1);
        check("back_idle", {30'h0, status[31:30]}, 32'd0);
        core_ready = 1'b0;
        step();
        check("layer_done_pulse", {31'h0, layer_done}, 32'h0);

        // Unaligned write
        set_depth(4, 4, 4, 4);
        do_arm(1'b0);
        check("core_layer0", {31'h0, core_layer}, 32'h0);
        host_ena[0] = 1'b1; host_wea[0] = 1'b1; a[0] = 20'h6;
        step();
        idle_wr();
        check("unal_we", {28'h0, bram_we}, 32'h0);
        check("unal_err", {30'h0, err_flags}, 32'h1);
        check("unal_status", status, 32'h4000_0001);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_err_held", {30'h0, err_flags}, 32'h1);
        check("abort_idle", {30'h0, status[31:30]}, 32'd0);

        // Out-of-range write, then a write while idle
        set_depth(4, 2, 4, 4);
        do_arm(1'b0);
        check("arm_clears_err", {30'h0, err_flags}, 32'h0);
        host_ena[1] = 1'b1; host_wea[1] = 1'b1; a[1] = 20'h8;
        step();
        idle_wr();
        check("oor_we", {28'h0, bram_we}, 32'h0);
        check("oor_err", {30'h0, err_flags}, 32'h2);
        check("oor_status", status, 32'h4000_0001);
        abort = 1'b1;
        step();
        abort = 1'b0;
        host_ena[2] = 1'b1; host_wea[2] = 1'b1; a[2] = 20'h0;
        step();
        idle_wr();
        check("idle_drop_status", status, 32'h0000_0002);
        check("idle_drop_err", {30'h0, err_flags}, 32'h2);

        // All depths zero
        set_depth(0, 0, 0, 0);
        do_arm(1'b0);
        check("zero_done", status, 32'h4F00_0000);
        step();
        check("zero_start", {31'h0, core_start}, 32'h1);
        core_ready = 1'b1;
        step();
        step();
        step();
        check("zero_layer_done", {31'h0, layer_done}, 32'h1);
        check("zero_idle", {30'h0, status[31:30]}, 32'd0);
        core_ready = 1'b0;

        // Abort mid-load, re-arm from count 0
        set_depth(4, 1, 4, 4);
        do_arm(1'b1);
        host_ena = 4'h3; host_wea = 4'h3; a[0] = 20'h0; a[1] = 20'h0;
        step();
        check("pre_abort_done", {28'h0, ch_done}, 32'h2);
        host_ena = 4'h1; a[0] = 20'h4;
        step();
        idle_wr();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_done_clr", {28'h0, ch_done}, 32'h0);
        check("abort_state", {30'h0, status[31:30]}, 32'd0);
        set_depth(2, 0, 0, 0);
        do_arm(1'b1);
        check("rearm_done", {28'h0, ch_done}, 32'hE);
        host_ena = 4'h1; host_wea = 4'h1; a[0] = 20'h0; d[0] = 32'hFFAB_CDEF;
        step();
        check("rearm_not_done", {28'h0, ch_done}, 32'hE);
        a[0] = 20'h4;
        step();
        idle_wr();
        check("rearm_done_all", {28'h0, ch_done}, 32'hF);
        check("rearm_addr", {14'h0, bram_addr[0 +: ADDR_W]}, 32'd1);
        step();
        step();
        check("rearm_run", {30'h0, status[31:30]}, 32'd3);

        // Asynchronous reset during RUN
        rst = 1'b1;
        #1;
        check("rst_status", status, 32'h0);
        check("rst_layer", {30'h0, core_layer, layer_done}, 32'h0);
        check("rst_bram", {8'h0, bram_din[0 +: DATA_W]}, 32'h0);
        check("rst_addr", {14'h0, bram_addr[0 +: ADDR_W]}, 32'h0);
        check("rst_misc", {26'h0, bram_we, err_flags}, 32'h0);
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
